// File: rtl/m_pipe_subtractor.sv
// -----------------------------------------------------------------------------
// m_pipe_subtractor
// Pipelined ripple-borrow subtractor: oDiff = iA - iB - iBorrowIn (mod 2^WIDTH).
// The WIDTH-bit operation is cut into CHUNK-bit slices. Slice stage k subtracts
// bits [k*CHUNK +: CHUNK] using the borrow produced by stage k-1. A final
// output register applies optional saturation and holds the result and flags.
// Latency is STAGES = WIDTH/CHUNK cycles from accept to oValid, 1 beat/cycle.
//
// Parameters:
//   WIDTH  operand/result width (must be a multiple of CHUNK, >= CHUNK)
//   CHUNK  bits subtracted per pipeline stage
//
// Configuration macro:
//   SUB_SAT_EN  adds iSatMode[1:0] (00 wrap, 01 unsigned sat, 10 signed sat,
//               11 wrap). oBorrow/oOverflow report the pre-saturation result,
//               oZero/oNeg describe the saturated oDiff.
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iValid/oReady       operand beat handshake (input side)
//   iA, iB, iBorrowIn   minuend, subtrahend, borrow-in to bit 0
//   oValid/iReady       result beat handshake (output side)
//   oDiff               difference
//   oBorrow             final borrow-out (unsigned A < B + borrow-in)
//   oZero, oNeg         oDiff == 0, oDiff[WIDTH-1]
//   oOverflow           signed overflow of the subtraction
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1.
// The whole pipe moves together: advance = !oValid || iReady, and oReady is
// exactly advance (combinational). When advance is 0 every register holds.
// -----------------------------------------------------------------------------
module m_pipe_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iBorrowIn,
`ifdef SUB_SAT_EN
    input  logic [1:0]       iSatMode,
`endif
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oDiff,
    output logic             oBorrow,
    output logic             oZero,
    output logic             oNeg,
    output logic             oOverflow
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    // Slice stage registers. r_d carries the diff slices completed so far;
    // r_a/r_b carry the operands so later stages can consume upper slices.
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_d   [STAGES];
    logic             r_brw [STAGES];

    // Output register
    logic             r_vld_o;
    logic [WIDTH-1:0] r_diff_o;
    logic             r_brw_o;
    logic             r_zero_o;
    logic             r_neg_o;
    logic             r_ovf_o;

    // Per-stage sources (stage 0 reads the ports, stage k reads stage k-1)
    logic             w_src_vld [STAGES];
    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic [WIDTH-1:0] w_src_d   [STAGES];
    logic             w_src_bin [STAGES];
    logic [WIDTH-1:0] w_nxt_d   [STAGES];
    logic             w_nxt_brw [STAGES];

`ifdef SUB_SAT_EN
    logic [1:0]       r_sat     [STAGES];
    logic [1:0]       w_src_sat [STAGES];
`endif

    logic             w_advance;
    logic             w_fin_ovf;
    logic [WIDTH-1:0] w_fin_diff;

    assign w_advance = !r_vld_o || iReady;
    assign oReady    = w_advance;

    always_comb begin
        w_src_vld[0] = iValid;
        w_src_a[0]   = iA;
        w_src_b[0]   = iB;
        w_src_d[0]   = '0;
        w_src_bin[0] = iBorrowIn;
`ifdef SUB_SAT_EN
        w_src_sat[0] = iSatMode;
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_d[k]   = r_d[k-1];
            w_src_bin[k] = r_brw[k-1];
`ifdef SUB_SAT_EN
            w_src_sat[k] = r_sat[k-1];
`endif
        end
    end

    // One CHUNK-bit subtract per stage; the extra MSB of the (CHUNK+1)-bit
    // result is the borrow-out, since the true result lies in [-2^CHUNK, 2^CHUNK).
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_d[k] = w_src_d[k];
            {w_nxt_brw[k], w_nxt_d[k][k*CHUNK +: CHUNK]} =
                {1'b0, w_src_a[k][k*CHUNK +: CHUNK]}
              - {1'b0, w_src_b[k][k*CHUNK +: CHUNK]}
              - {{CHUNK{1'b0}}, w_src_bin[k]};
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_d[k]   <= '0;
                r_brw[k] <= 1'b0;
`ifdef SUB_SAT_EN
                r_sat[k] <= 2'b00;
`endif
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_src_vld[k];
                // Payload only moves with a real beat; bubbles leave it alone.
                if (w_src_vld[k]) begin
                    r_a[k]   <= w_src_a[k];
                    r_b[k]   <= w_src_b[k];
                    r_d[k]   <= w_nxt_d[k];
                    r_brw[k] <= w_nxt_brw[k];
`ifdef SUB_SAT_EN
                    r_sat[k] <= w_src_sat[k];
`endif
                end
            end
        end
    end

    // Signed overflow: operands of different sign and result sign differs from A.
    assign w_fin_ovf = (r_a[STAGES-1][WIDTH-1] != r_b[STAGES-1][WIDTH-1]) &&
                       (r_d[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

    always_comb begin
        w_fin_diff = r_d[STAGES-1];
`ifdef SUB_SAT_EN
        case (r_sat[STAGES-1])
            2'b01: if (r_brw[STAGES-1]) w_fin_diff = '0;
            2'b10: if (w_fin_ovf) w_fin_diff = r_a[STAGES-1][WIDTH-1] ? MIN_NEG : MAX_POS;
            default: w_fin_diff = r_d[STAGES-1];
        endcase
`endif
    end

    // Output register: result and flags only change on advance with a real
    // beat, so they hold during back-pressure and while oValid is low.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_vld_o  <= 1'b0;
            r_diff_o <= '0;
            r_brw_o  <= 1'b0;
            r_zero_o <= 1'b0;
            r_neg_o  <= 1'b0;
            r_ovf_o  <= 1'b0;
        end else if (w_advance) begin
            r_vld_o <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) begin
                r_diff_o <= w_fin_diff;
                r_brw_o  <= r_brw[STAGES-1];
                r_zero_o <= (w_fin_diff == '0);
                r_neg_o  <= w_fin_diff[WIDTH-1];
                r_ovf_o  <= w_fin_ovf;
            end
        end
    end

    assign oValid    = r_vld_o;
    assign oDiff     = r_diff_o;
    assign oBorrow   = r_brw_o;
    assign oZero     = r_zero_o;
    assign oNeg      = r_neg_o;
    assign oOverflow = r_ovf_o;

endmodule

// File: tb/tb_m_pipe_subtractor.sv
// -----------------------------------------------------------------------------
// tb_m_pipe_subtractor
// Directed and randomized stimulus for m_pipe_subtractor (WIDTH=16, CHUNK=4).
// Expected results come from an arithmetic model of A - B - borrow-in and are
// queued at accept time; every delivered output beat is checked against the
// head of the queue.
// -----------------------------------------------------------------------------
module tb_m_pipe_subtractor;

    localparam int W      = 16;
    localparam int CH     = 4;
    localparam int STAGES = W / CH;

    // ---------------- clock / reset ----------------
    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic          iRst;
    logic          iValid;
    logic          oReady;
    logic [W-1:0]  iA;
    logic [W-1:0]  iB;
    logic          iBorrowIn;
`ifdef SUB_SAT_EN
    logic [1:0]    iSatMode;
`endif
    logic          oValid;
    logic          iReady;
    logic [W-1:0]  oDiff;
    logic          oBorrow;
    logic          oZero;
    logic          oNeg;
    logic          oOverflow;

    m_pipe_subtractor #(.WIDTH(W), .CHUNK(CH)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iA        (iA),
        .iB        (iB),
        .iBorrowIn (iBorrowIn),
`ifdef SUB_SAT_EN
        .iSatMode  (iSatMode),
`endif
        .oValid    (oValid),
        .iReady    (iReady),
        .oDiff     (oDiff),
        .oBorrow   (oBorrow),
        .oZero     (oZero),
        .oNeg      (oNeg),
        .oOverflow (oOverflow)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_flag_q[$];   // {borrow, zero, neg, overflow}
    int           exp_cyc_q[$];

    int n_cmp       = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int n_delivered = 0;
    int n_not_ready = 0;
    bit lat_exact   = 1'b0;
    bit last_acc    = 1'b0;
    bit hold_prev   = 1'b0;
    logic [W-1:0] prev_diff;
    logic [3:0]   prev_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin, input logic [1:0] sm,
                                  output logic [W-1:0] d, output logic [3:0] f);
        int ua, ub, sa, sb, ures, sres;
        logic brw, ovf;
        ua   = a;
        ub   = b;
        sa   = $signed(a);
        sb   = $signed(b);
        ures = ua - ub - int'(bin);
        sres = sa - sb - int'(bin);
        brw  = (ures < 0);
        ovf  = (sres > 32767) || (sres < -32768);
        d    = ures[W-1:0];
        if (sm == 2'b01 && brw) d = '0;
        if (sm == 2'b10 && ovf) d = (sa < 0) ? 16'h8000 : 16'h7FFF;
        f = {brw, (d == '0), d[W-1], ovf};
    endfunction

    // One clock: observe at negedge, then let the edge happen.
    task automatic step();
        logic [W-1:0] ed;
        logic [3:0]   ef;
        logic [1:0]   sm;
        int           acc;
        @(negedge iClk);
`ifdef SUB_SAT_EN
        sm = iSatMode;
`else
        sm = 2'b00;
`endif
        last_acc = 1'b0;
        if (hold_prev) begin
            check("stall_valid", {31'd0, oValid}, 32'd1);
            check("stall_diff", {16'd0, oDiff}, {16'd0, prev_diff});
            check("stall_flags", {28'd0, oBorrow, oZero, oNeg, oOverflow}, {28'd0, prev_flags});
        end
        hold_prev  = oValid && !iReady && !iRst;
        prev_diff  = oDiff;
        prev_flags = {oBorrow, oZero, oNeg, oOverflow};
        if (iRst) begin
            exp_q.delete();
            exp_flag_q.delete();
            exp_cyc_q.delete();
        end else begin
            check("ready_rule", {31'd0, oReady}, {31'd0, (!oValid || iReady)});
            if (!oReady) n_not_ready++;
            if (oValid && iReady) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", {31'd0, oValid}, 32'd0);
                end else begin
                    ed  = exp_q.pop_front();
                    ef  = exp_flag_q.pop_front();
                    acc = exp_cyc_q.pop_front();
                    n_delivered++;
                    check("diff", {16'd0, oDiff}, {16'd0, ed});
                    check("flags_bzno", {28'd0, oBorrow, oZero, oNeg, oOverflow}, {28'd0, ef});
                    if (lat_exact) check("latency", cyc - acc - 1, STAGES);
                end
            end
            if (iValid && oReady) begin
                model(iA, iB, iBorrowIn, sm, ed, ef);
                exp_q.push_back(ed);
                exp_flag_q.push_back(ef);
                exp_cyc_q.push_back(cyc);
                last_acc = 1'b1;
            end
        end
        @(posedge iClk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [1:0] sm);
        int n;
        iA        = a;
        iB        = b;
        iBorrowIn = bin;
`ifdef SUB_SAT_EN
        iSatMode  = sm;
`else
        if (sm != 2'b00) iBorrowIn = bin;  // saturation modes need SUB_SAT_EN
`endif
        iValid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) check("accept_timeout", {31'd0, oReady}, 32'd1);
        // Garbage on the data inputs while idle must not matter.
        iValid    = 1'b0;
        iA        = W'($urandom);
        iB        = W'($urandom);
        iBorrowIn = 1'($urandom);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sent, d0, nr0, c;
        iRst      = 1'b1;
        iValid    = 1'b0;
        iA        = '0;
        iB        = '0;
        iBorrowIn = 1'b0;
        iReady    = 1'b1;
`ifdef SUB_SAT_EN
        iSatMode  = 2'b00;
`endif
        #1;

        // Reset: two cycles, then check idle state
        step();
        step();
        iRst = 1'b0;
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_diff", {16'd0, oDiff}, 32'd0);
        check("rst_flags", {28'd0, oBorrow, oZero, oNeg, oOverflow}, 32'd0);
        check("rst_ready", {31'd0, oReady}, 32'd1);

        // Directed values with no back-pressure: exact latency
        lat_exact = 1'b1;
        send(16'h1234, 16'h0234, 1'b0, 2'b00);
        drain(20);
        send(16'h0000, 16'h0001, 1'b0, 2'b00);
        send(16'h0005, 16'h0004, 1'b1, 2'b00);
        send(16'h8000, 16'h0001, 1'b0, 2'b00);
        send(16'h7FFF, 16'hFFFF, 1'b0, 2'b00);
        send(16'hFFFF, 16'hFFFF, 1'b1, 2'b00);
        send(16'h000F, 16'h0010, 1'b0, 2'b00);
        drain(20);
`ifdef SUB_SAT_EN
        send(16'h8000, 16'h0001, 1'b0, 2'b10);
        send(16'h7FFF, 16'hFFFF, 1'b0, 2'b10);
        send(16'h0000, 16'h0001, 1'b0, 2'b01);
        send(16'h8000, 16'h0001, 1'b0, 2'b11);
        drain(20);
`endif

        // Back-pressure: 8 beats back-to-back, iReady low 5 cycles mid-stream
        lat_exact = 1'b0;
        d0   = n_delivered;
        nr0  = n_not_ready;
        sent = 0;
        c    = 0;
        while ((sent < 8 || exp_q.size() != 0) && c < 60) begin
            iValid    = (sent < 8);
            iA        = W'($urandom);
            iB        = W'($urandom);
            iBorrowIn = 1'($urandom);
            iReady    = !(c >= 5 && c < 10);
            step();
            if (last_acc) sent++;
            c++;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        check("bp_delivered", n_delivered - d0, 32'd8);
        check("bp_ready_dropped", {31'd0, (n_not_ready > nr0)}, 32'd1);

        // Reset mid-flight: three beats discarded, next beat has full latency
        send(16'h1111, 16'h0001, 1'b0, 2'b00);
        send(16'h2222, 16'h0002, 1'b0, 2'b00);
        send(16'h3333, 16'h0003, 1'b0, 2'b00);
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        d0 = n_delivered;
        repeat (10) step();
        check("rst_mid_no_output", n_delivered - d0, 32'd0);
        check("rst_mid_valid_low", {31'd0, oValid}, 32'd0);
        lat_exact = 1'b1;
        send(16'hABCD, 16'h1234, 1'b1, 2'b00);
        drain(20);
        check("rst_mid_next_beat", n_delivered - d0, 32'd1);

        // Randomized traffic with random back-pressure
        lat_exact = 1'b0;
        for (int i = 0; i < 300; i++) begin
            iValid    = ($urandom_range(0, 3) != 0);
            iA        = W'($urandom);
            iB        = W'($urandom);
            iBorrowIn = 1'($urandom);
`ifdef SUB_SAT_EN
            iSatMode  = 2'($urandom_range(0, 3));
`endif
            iReady    = ($urandom_range(0, 3) != 0);
            step();
        end
        iValid = 1'b0;
        iReady = 1'b1;
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
